// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite initiator: turns one valid/ready command into a full AXI4-Lite
// write or read. One transaction is in flight at a time, and its result is
// held on the rsp_* port until the requester consumes it.
//
// Ports:
//   ACLK, ARESET        clock (rising edge) and async active-high reset
//   cmd_*               command request; cmd_ready is high only in IDLE
//   rsp_*               held response: kind, read data, BRESP/RRESP, timeout
//   busy                a transaction is in progress
//   M_AXI_AW*/W*/B*     AXI4-Lite write address, data and response channels
//   M_AXI_AR*/R*        AXI4-Lite read address and data channels
//
// Build option: define AXI_MASTER_TIMEOUT_EN to abort transactions that wait
// longer than TIMEOUT_CYCLES. When the option is off, rsp_timeout is tied to 0.

module axi_lite_master_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_nxt, rdata_nxt;
    logic [STRB_WIDTH-1:0]   wstrb_nxt;
    logic                    awvalid_nxt, wvalid_nxt, arvalid_nxt;
    logic                    bready_nxt, rready_nxt;
    logic                    aw_done, aw_done_nxt;
    logic                    w_done, w_done_nxt;
    logic                    rvalid_nxt, rwrite_nxt;
    logic [1:0]              resp_nxt;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY  & M_AXI_BVALID;
    assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY  & M_AXI_RVALID;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wr, wr_nxt;
    logic             tout, tout_nxt;

    assign rsp_timeout = tout;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_ARADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt           <= '0;
            wr            <= 1'b0;
            tout          <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            M_AXI_AWADDR  <= awaddr_nxt;
            M_AXI_WDATA   <= wdata_nxt;
            M_AXI_WSTRB   <= wstrb_nxt;
            M_AXI_ARADDR  <= araddr_nxt;
            M_AXI_AWVALID <= awvalid_nxt;
            M_AXI_WVALID  <= wvalid_nxt;
            M_AXI_ARVALID <= arvalid_nxt;
            M_AXI_BREADY  <= bready_nxt;
            M_AXI_RREADY  <= rready_nxt;
            aw_done       <= aw_done_nxt;
            w_done        <= w_done_nxt;
            rsp_valid     <= rvalid_nxt;
            rsp_write     <= rwrite_nxt;
            rsp_rdata     <= rdata_nxt;
            rsp_resp      <= resp_nxt;
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt           <= cnt_nxt;
            wr            <= wr_nxt;
            tout          <= tout_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        awaddr_nxt  = M_AXI_AWADDR;
        wdata_nxt   = M_AXI_WDATA;
        wstrb_nxt   = M_AXI_WSTRB;
        araddr_nxt  = M_AXI_ARADDR;
        awvalid_nxt = M_AXI_AWVALID;
        wvalid_nxt  = M_AXI_WVALID;
        arvalid_nxt = M_AXI_ARVALID;
        bready_nxt  = M_AXI_BREADY;
        rready_nxt  = M_AXI_RREADY;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        rvalid_nxt  = rsp_valid;
        rwrite_nxt  = rsp_write;
        rdata_nxt   = rsp_rdata;
        resp_nxt    = rsp_resp;
`ifdef AXI_MASTER_TIMEOUT_EN
        cnt_nxt     = cnt;
        wr_nxt      = wr;
        tout_nxt    = tout;
`endif

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        state_nxt   = WR_REQ;
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                    end else begin
                        state_nxt   = RD_REQ;
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order or together.
                if (aw_hs) begin
                    awvalid_nxt = 1'b0;
                    aw_done_nxt = 1'b1;
                end
                if (w_hs) begin
                    wvalid_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    state_nxt  = WR_RESP;
                    bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt  = RSP;
                    bready_nxt = 1'b0;
                    rvalid_nxt = 1'b1;
                    rwrite_nxt = 1'b1;
                    rdata_nxt  = '0;
                    resp_nxt   = M_AXI_BRESP;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_nxt   = RD_RESP;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_nxt  = RSP;
                    rready_nxt = 1'b0;
                    rvalid_nxt = 1'b1;
                    rwrite_nxt = 1'b0;
                    rdata_nxt  = M_AXI_RDATA;
                    resp_nxt   = M_AXI_RRESP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt  = IDLE;
                    rvalid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        if (state == IDLE) begin
            // Holding cnt at 0 in IDLE is what clears it on WR_REQ/RD_REQ entry.
            cnt_nxt = '0;
            wr_nxt  = cmd_write;
            if (cmd_valid)
                tout_nxt = 1'b0;
        end else if (state != RSP) begin
            cnt_nxt = cnt + CNT_W'(1);
            // Abort wins over any handshake landing on the same edge.
            if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                state_nxt   = RSP;
                awvalid_nxt = 1'b0;
                wvalid_nxt  = 1'b0;
                arvalid_nxt = 1'b0;
                bready_nxt  = 1'b0;
                rready_nxt  = 1'b0;
                rvalid_nxt  = 1'b1;
                rwrite_nxt  = wr;
                rdata_nxt   = '0;
                resp_nxt    = 2'b10;
                tout_nxt    = 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl: the slave side is driven by hand,
// cycle by cycle, and every expected value is a hand-computed constant.

module tb_axi_lite_master_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int tests = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_master_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_rdy"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        ARESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        #1;
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_awaddr", 32'(awaddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        tick();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: minimal-latency write
        awready = 1'b1; wready = 1'b1;
        send(1'b1, 12'h000, 32'h1, 4'hF);
        chk("t1_awvalid", 32'(awvalid), 32'd1);
        chk("t1_wvalid", 32'(wvalid), 32'd1);
        chk("t1_wdata", wdata, 32'h1);
        chk("t1_wstrb", 32'(wstrb), 32'hF);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        chk("t1_awvalid_drop", 32'(awvalid), 32'd0);
        chk("t1_wvalid_drop", 32'(wvalid), 32'd0);
        chk("t1_bready", 32'(bready), 32'd1);
        chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
        tick();
        bvalid = 1'b0;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("t1_rsp_write", 32'(rsp_write), 32'd1);
        chk("t1_rsp_rdata", rsp_rdata, 32'd0);
        chk("t1_bready_drop", 32'(bready), 32'd0);
        consume("t1");

        // 2: read of STATUS, data one cycle after AR
        arready = 1'b1;
        send(1'b0, 12'h004, 32'h0, 4'h0);
        chk("t2_arvalid", 32'(arvalid), 32'd1);
        chk("t2_araddr", 32'(araddr), 32'h004);
        rvalid = 1'b1; rdata = 32'h0000_0A00; rresp = 2'b00;
        tick();
        chk("t2_arvalid_drop", 32'(arvalid), 32'd0);
        chk("t2_rready", 32'(rready), 32'd1);
        tick();
        rvalid = 1'b0;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h0000_0A00);
        chk("t2_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("t2_rsp_write", 32'(rsp_write), 32'd0);
        chk("t2_rready_drop", 32'(rready), 32'd0);
        consume("t2");

        // 3: AWREADY late by 3 cycles, SLVERR passed through
        awready = 1'b0; wready = 1'b1;
        send(1'b1, 12'h000, 32'h2, 4'h3);
        chk("t3_c1_awvalid", 32'(awvalid), 32'd1);
        chk("t3_c1_wvalid", 32'(wvalid), 32'd1);
        tick();
        chk("t3_wvalid_drop", 32'(wvalid), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("t3_c%0d_awvalid", c), 32'(awvalid), 32'd1);
            chk($sformatf("t3_c%0d_awaddr", c), 32'(awaddr), 32'h000);
            chk($sformatf("t3_c%0d_bready", c), 32'(bready), 32'd0);
            if (c == 4) awready = 1'b1;
            tick();
        end
        chk("t3_awvalid_drop", 32'(awvalid), 32'd0);
        chk("t3_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t3_rsp_resp", 32'(rsp_resp), 32'd2);
        chk("t3_one_b_hs", 32'(bready), 32'd0);
        tick();
        bvalid = 1'b0;
        chk("t3_still_one_b", 32'(bready), 32'd0);
        chk("t3_resp_held", 32'(rsp_resp), 32'd2);
        consume("t3");

        // 4: response back-pressure with a second command waiting
        bvalid = 1'b1; bresp = 2'b00;
        send(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF);
        chk("t4_awaddr", 32'(awaddr), 32'h010);
        chk("t4_wdata", wdata, 32'hDEAD_BEEF);
        tick();
        tick();
        bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h004;
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_rsp_write", 32'(rsp_write), 32'd1);
            chk("t4_hold_rsp_resp", 32'(rsp_resp), 32'd0);
            chk("t4_hold_rsp_rdata", rsp_rdata, 32'd0);
            chk("t4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("t4_hold_arvalid", 32'(arvalid), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t4_rsp_clr", 32'(rsp_valid), 32'd0);
        chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t4_not_early", 32'(arvalid), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("t4_accept2", 32'(arvalid), 32'd1);
        chk("t4_araddr", 32'(araddr), 32'h004);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b11;
        tick();
        tick();
        rvalid = 1'b0;
        chk("t4_rd_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rd_rdata", rsp_rdata, 32'h1234_5678);
        chk("t4_rd_decerr", 32'(rsp_resp), 32'd3);
        consume("t4");

        // 5: reset in WR_RESP acts without a clock edge
        send(1'b1, 12'h020, 32'h5, 4'h1);
        tick();
        chk("t5_bready", 32'(bready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        #2 ARESET = 1'b1;
        #1;
        chk("t5_rst_bready", 32'(bready), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_awaddr", 32'(awaddr), 32'd0);
        #1 ARESET = 1'b0;
        tick();
        chk("t5_no_partial_rsp", 32'(rsp_valid), 32'd0);
        rvalid = 1'b1; rdata = 32'h55; rresp = 2'b00;
        send(1'b0, 12'h008, 32'h0, 4'h0);
        chk("t5_araddr", 32'(araddr), 32'h008);
        tick();
        tick();
        rvalid = 1'b0;
        chk("t5_rd_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rd_rdata", rsp_rdata, 32'h55);
        chk("t5_rd_write", 32'(rsp_write), 32'd0);
        consume("t5");

        // 6: slave never answers B
        bvalid = 1'b0;
        send(1'b1, 12'h000, 32'h7, 4'hF);
`ifdef AXI_MASTER_TIMEOUT_EN
        begin
            int n;
            n = 1;
            while (!rsp_valid && n < 400) begin
                tick();
                n++;
            end
            chk("t6_to_seen", 32'(rsp_valid), 32'd1);
            chk("t6_to_latency_ok", 32'(n >= 256 && n <= 258), 32'd1);
            chk("t6_to_flag", 32'(rsp_timeout), 32'd1);
            chk("t6_to_resp", 32'(rsp_resp), 32'd2);
            chk("t6_to_rdata", rsp_rdata, 32'd0);
            chk("t6_to_write", 32'(rsp_write), 32'd1);
            chk("t6_to_bready", 32'(bready), 32'd0);
            consume("t6");
        end
`else
        repeat (300) tick();
        chk("t6_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_wait_timeout", 32'(rsp_timeout), 32'd0);
        chk("t6_wait_bready", 32'(bready), 32'd1);
        chk("t6_wait_busy", 32'(busy), 32'd1);
        ARESET = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        ARESET = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_ctrl.md
Name: axi_lite_master_ctrl

Overview:
AXI4-Lite initiator that turns single-beat commands on a simple valid/ready command port into complete AXI4-Lite write or read transactions. It drives the CSR slave port of axi_csr_fifo_top, for example CONTROL writes at 0x000 and STATUS polls at 0x004, from on-chip sequencing logic instead of a bench. It handles one outstanding transaction at a time and returns the response and read data on a held response port.

Parameters:
ADDR_WIDTH, 12, AXI address width
DATA_WIDTH, 32, AXI data width; WSTRB width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, response-wait limit in cycles; used only when AXI_MASTER_TIMEOUT_EN is defined

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  captured BRESP/RRESP
rsp_timeout  out  1  transaction aborted by timeout
busy  out  1  state != IDLE
M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  ADDR_WIDTH/1/1  write address channel
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  ADDR_WIDTH/1/1  read address channel
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset (async, immediate): state IDLE; all VALID, READY and rsp_* outputs 0; AW/W/AR address and data registers 0; busy 0.
- All AXI outputs are registered. A VALID never depends combinationally on its READY.
- A channel handshake occurs on a rising edge where VALID and READY are both 1.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_addr, cmd_wdata, cmd_wstrb and cmd_write. Go to WR_REQ if cmd_write=1, otherwise RD_REQ.
  - WR_REQ: AWVALID and WVALID are both asserted the cycle after acceptance. Each channel is tracked independently with aw_done and w_done, and each VALID drops on the edge of its own handshake. Handshakes on the same edge or in either order are legal. When both are done, go to WR_RESP.
  - WR_RESP: BREADY=1. On the B handshake, capture BRESP, set rsp_write=1 and rsp_rdata=0, then go to RSP.
  - RD_REQ: ARVALID=1 until the AR handshake, then go to RD_RESP.
  - RD_RESP: RREADY=1. On the R handshake, capture RDATA and RRESP, set rsp_write=0, then go to RSP.
  - RSP: rsp_valid=1 with all rsp_* stable. When rsp_ready=1, go to IDLE; cmd_ready is high the following cycle.
- While VALID is high, AWADDR, WDATA, WSTRB and ARADDR remain stable.
- Minimum latency with slave always ready: command accepted at edge 0, VALIDs high in cycle 1, BREADY or RREADY high in cycle 2, rsp_valid high in cycle 3.
- A command presented while busy is not accepted and must be held by the requester.
- BRESP/RRESP values of SLVERR or DECERR are passed through unchanged. The block does not retry.
- Reset asserted in any state drops the bus immediately; no partial response is produced.

Optional Feature:
AXI_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WR_REQ/RD_REQ and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES, all VALID/READY drop the next cycle and the state goes to RSP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: rsp_timeout is tied to 0, there is no counter, and the block waits indefinitely.

Test Plan:
1. Write cmd addr 0x000, data 0x1, wstrb 0xF; slave ready always, BRESP=0 -> AWVALID/WVALID high for exactly 1 cycle, rsp_valid in cycle 3 after acceptance, rsp_resp=0, rsp_write=1.
2. Read cmd addr 0x004; slave returns RDATA=0x0000_0A00 one cycle after AR -> rsp_rdata=0x0000_0A00 (level 10 in [15:8]), rsp_resp=0, rsp_write=0.
3. Write with WREADY immediate and AWREADY delayed 3 cycles -> WVALID drops after 1 cycle; AWVALID and AWADDR=0x000 held stable for 4 cycles; exactly one B handshake.
4. rsp_ready held low 5 cycles with a second cmd_valid pending -> rsp_* stable, cmd_ready=0 throughout; second command accepted the cycle after rsp_ready.
5. ARESET pulsed during WR_RESP -> BREADY, busy and rsp_valid go to 0 without a clock edge; the next read completes normally.
6. With AXI_MASTER_TIMEOUT_EN, slave never asserts BVALID -> after 256 cycles rsp_valid=1, rsp_timeout=1, rsp_resp=2'b10. Without the macro, rsp_timeout stays 0.
